// File: rtl/reg_bank_pkg.sv
// Shared defaults for the register bank and the index of the hard-wired zero register.
package reg_bank_pkg;

   localparam int WIDTH_DEF = 32;
   localparam int DEPTH_DEF = 32;
   localparam int AW_DEF    = 5;
   localparam int ZERO_REG  = 0;

endpackage

// File: rtl/decoder5to32.sv
// One-hot write-enable decoder: exactly one output bit set when enabled, none otherwise.
module decoder5to32
   import reg_bank_pkg::*;
#(
   parameter int AW    = AW_DEF,
   parameter int DEPTH = DEPTH_DEF
) (
   input  logic [AW-1:0]    addr,
   input  logic             en,
   output logic [DEPTH-1:0] onehot
);

   // Default to all-zero so an unknown address with en low selects nothing.
   always_comb begin
      onehot = '0;
      if (en) begin
         onehot[addr] = 1'b1;
      end
   end

endmodule

// File: rtl/mux2_32.sv
// Two-input word multiplexer used as the building block of the read trees.
module mux2_32 #(
   parameter int W = 32
) (
   input  logic [W-1:0] a,
   input  logic [W-1:0] b,
   input  logic         sel,
   output logic [W-1:0] y
);

   assign y = sel ? b : a;

endmodule

// File: rtl/reg_bank_demux.sv
// Register bank with one decoded write port, two combinational read ports,
// write-through bypass, a hard-wired zero register and a write acknowledge.
module reg_bank_demux
   import reg_bank_pkg::*;
#(
   parameter int WIDTH = WIDTH_DEF,
   parameter int DEPTH = DEPTH_DEF,
   parameter int AW    = AW_DEF
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             WrEn,
   input  logic [AW-1:0]    WrAddr,
   input  logic [WIDTH-1:0] WrData,
   input  logic [AW-1:0]    RdAddr1,
   input  logic [AW-1:0]    RdAddr2,
   output logic [WIDTH-1:0] RdData1,
   output logic [WIDTH-1:0] RdData2,
   output logic             WrAck
);

   // DEPTH is assumed to equal 2**AW; the read trees rely on it.

   logic             wr_commit;
   logic [DEPTH-1:0] wr_sel;
   logic             dec_unused;
   logic [WIDTH-1:0] regs [DEPTH];
   logic [AW-1:0]    rd_addr [2];
   logic [WIDTH-1:0] tree_out [2];
   logic             bypass1;
   logic             bypass2;

   // A write only counts when it targets a real register; address zero is discarded.
   assign wr_commit = WrEn && (WrAddr != AW'(ZERO_REG));

   decoder5to32 #(
      .AW    (AW),
      .DEPTH (DEPTH)
   ) u_dec (
      .addr   (WrAddr),
      .en     (wr_commit),
      .onehot (wr_sel)
   );

   // Register zero has no storage, so its decoder output goes nowhere.
   assign dec_unused = wr_sel[0];

   assign regs[0] = '0;

   for (genvar i = 1; i < DEPTH; i++) begin : g_reg
      logic [WIDTH-1:0] q;

      // Per-register storage, loaded only when its decoder line is active.
      always_ff @(posedge Clk or negedge Reset_n) begin
         if (!Reset_n) begin
            q <= '0;
         end else if (wr_sel[i]) begin
            q <= WrData;
         end
      end

      assign regs[i] = q;
   end

   assign rd_addr[0] = RdAddr1;
   assign rd_addr[1] = RdAddr2;

   // Binary mux tree per read port: stage s halves the candidates using address bit s-1.
   for (genvar p = 0; p < 2; p++) begin : g_port
      for (genvar s = 1; s <= AW; s++) begin : g_stage
         logic [WIDTH-1:0] node [DEPTH >> s];
         for (genvar n = 0; n < (DEPTH >> s); n++) begin : g_node
            if (s == 1) begin : g_leaf
               mux2_32 #(.W(WIDTH)) u_mux (
                  .a   (regs[2*n]),
                  .b   (regs[2*n+1]),
                  .sel (rd_addr[p][0]),
                  .y   (node[n])
               );
            end else begin : g_inner
               mux2_32 #(.W(WIDTH)) u_mux (
                  .a   (g_stage[s-1].node[2*n]),
                  .b   (g_stage[s-1].node[2*n+1]),
                  .sel (rd_addr[p][s-1]),
                  .y   (node[n])
               );
            end
         end
      end
      assign tree_out[p] = g_stage[AW].node[0];
   end

   // Forward the in-flight write to a matching read port; suppressed while in reset.
   assign bypass1 = Reset_n && wr_commit && (RdAddr1 == WrAddr);
   assign bypass2 = Reset_n && wr_commit && (RdAddr2 == WrAddr);
   assign RdData1 = bypass1 ? WrData : tree_out[0];
   assign RdData2 = bypass2 ? WrData : tree_out[1];

   // Acknowledge pulse one cycle after a committed write.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         WrAck <= 1'b0;
      end else begin
         WrAck <= wr_commit;
      end
   end

endmodule

// File: tb/tb_reg_bank_demux.sv
// Self-checking bench for reg_bank_demux: directed scenarios plus randomized traffic
// compared against an array model of the register file.
module tb_reg_bank_demux;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        WrEn;
   logic [4:0]  WrAddr;
   logic [31:0] WrData;
   logic [4:0]  RdAddr1;
   logic [4:0]  RdAddr2;
   logic [31:0] RdData1;
   logic [31:0] RdData2;
   logic        WrAck;

   int errors = 0;
   int checks = 0;
   logic [31:0] model [32];

   reg_bank_demux dut (
      .Clk     (Clk),
      .Reset_n (Reset_n),
      .WrEn    (WrEn),
      .WrAddr  (WrAddr),
      .WrData  (WrData),
      .RdAddr1 (RdAddr1),
      .RdAddr2 (RdAddr2),
      .RdData1 (RdData1),
      .RdData2 (RdData2),
      .WrAck   (WrAck)
   );

   // Free-running clock, rising edges at 5, 15, 25, ...
   always #5 Clk = ~Clk;

   task automatic checkValue(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   // Expected read data from the register-file rules: zero in reset, bypass on a live write, else stored word.
   function automatic logic [31:0] expectedRead(input logic [4:0] a);
      if (Reset_n !== 1'b1) return 32'h0;
      if (WrEn === 1'b1 && WrAddr !== 5'd0 && a === WrAddr) return WrData;
      return model[a];
   endfunction

   task automatic applyStimulus(input logic we, input logic [4:0] wa, input logic [31:0] wd,
                                input logic [4:0] ra1, input logic [4:0] ra2);
      @(negedge Clk);
      WrEn    = we;
      WrAddr  = wa;
      WrData  = wd;
      RdAddr1 = ra1;
      RdAddr2 = ra2;
   endtask

   task automatic checkOutput(input string tag);
      #1;
      checkValue({tag, "_rd1"}, RdData1, expectedRead(RdAddr1));
      checkValue({tag, "_rd2"}, RdData2, expectedRead(RdAddr2));
   endtask

   task automatic clockEdge(input string tag);
      logic commit;
      commit = (Reset_n === 1'b1) && (WrEn === 1'b1) && (WrAddr !== 5'd0);
      @(posedge Clk);
      if (commit) model[WrAddr] = WrData;
      #1;
      checkValue({tag, "_ack"}, {31'b0, WrAck}, {31'b0, commit});
   endtask

   initial begin
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      Reset_n = 1'b1;
      WrEn    = 1'b0;
      WrAddr  = 5'd0;
      WrData  = 32'h0;
      RdAddr1 = 5'd0;
      RdAddr2 = 5'd0;
      #1 Reset_n = 1'b0;

      // Reset: every address on both ports reads zero, no acknowledge
      for (int a = 0; a < 32; a++) begin
         RdAddr1 = 5'(a);
         RdAddr2 = 5'(31 - a);
         #1;
         checkValue("reset_rd1", RdData1, 32'h0);
         checkValue("reset_rd2", RdData2, 32'h0);
      end
      checkValue("reset_ack", {31'b0, WrAck}, 32'h0);

      // Release reset together with a write; first edge must accept it
      @(negedge Clk);
      Reset_n = 1'b1;
      WrEn    = 1'b1;
      WrAddr  = 5'd5;
      WrData  = 32'hDEADBEEF;
      RdAddr1 = 5'd5;
      RdAddr2 = 5'd4;
      checkOutput("first_write_bypass");
      clockEdge("first_write");

      applyStimulus(1'b0, 5'd0, 32'h0, 5'd5, 5'd4);
      #1;
      checkValue("addr5_readback", RdData1, 32'hDEADBEEF);
      checkValue("addr4_zero", RdData2, 32'h0);
      checkValue("addr5_ack", {31'b0, WrAck}, 32'h1);

      // Writes to register zero are discarded and not acknowledged
      applyStimulus(1'b1, 5'd0, 32'hFFFFFFFF, 5'd0, 5'd5);
      checkOutput("zero_write_same");
      clockEdge("zero_write");
      applyStimulus(1'b0, 5'd0, 32'h0, 5'd0, 5'd0);
      #1;
      checkValue("zero_reads_zero", RdData1, 32'h0);
      checkValue("zero_no_ack", {31'b0, WrAck}, 32'h0);

      // Same-cycle bypass on both ports
      applyStimulus(1'b1, 5'd7, 32'h12345678, 5'd7, 5'd7);
      #1;
      checkValue("bypass_rd1", RdData1, 32'h12345678);
      checkValue("bypass_rd2", RdData2, 32'h12345678);
      clockEdge("bypass");

      // Top register written, then a disabled write leaves it alone
      applyStimulus(1'b1, 5'd31, 32'hA5A5A5A5, 5'd31, 5'd7);
      checkOutput("addr31_write");
      clockEdge("addr31_write");
      applyStimulus(1'b0, 5'd31, 32'h0, 5'd31, 5'd7);
      checkOutput("addr31_hold_same");
      clockEdge("addr31_hold");
      #1;
      checkValue("addr31_kept", RdData1, 32'hA5A5A5A5);

      // Unknown write address with the enable low must not disturb storage
      applyStimulus(1'b0, 5'bx, 32'hCAFEF00D, 5'd5, 5'd31);
      clockEdge("xaddr");
      for (int a = 0; a < 32; a++) begin
         RdAddr1 = 5'(a);
         RdAddr2 = 5'(a);
         checkOutput("xaddr_scan");
      end

      // Randomized traffic against the array model
      for (int k = 0; k < 300; k++) begin
         logic        we;
         logic [4:0]  wa;
         logic [4:0]  ra1;
         logic [4:0]  ra2;
         we  = 1'($urandom_range(0, 1));
         wa  = 5'($urandom_range(0, 31));
         ra1 = ($urandom_range(0, 3) == 0) ? wa : 5'($urandom_range(0, 31));
         ra2 = ($urandom_range(0, 3) == 0) ? ra1 : 5'($urandom_range(0, 31));
         applyStimulus(we, wa, $urandom, ra1, ra2);
         checkOutput("random");
         clockEdge("random");
      end

      // Asynchronous reset mid-sequence, coincident with a write
      applyStimulus(1'b1, 5'd3, 32'h1, 5'd3, 5'd3);
      checkOutput("addr3_write");
      clockEdge("addr3_write");
      @(negedge Clk);
      WrEn    = 1'b1;
      WrAddr  = 5'd9;
      WrData  = 32'h55AA55AA;
      RdAddr1 = 5'd3;
      RdAddr2 = 5'd9;
      #2 Reset_n = 1'b0;
      #1;
      checkValue("async_addr3_clear", RdData1, 32'h0);
      checkValue("async_bypass_off", RdData2, 32'h0);
      checkValue("async_ack_clear", {31'b0, WrAck}, 32'h0);
      for (int i = 0; i < 32; i++) model[i] = 32'h0;
      clockEdge("in_reset");
      @(negedge Clk);
      Reset_n = 1'b1;
      WrEn    = 1'b0;
      #1;
      checkValue("lost_write_addr9", RdData2, 32'h0);
      checkValue("after_reset_addr3", RdData1, 32'h0);

      // Short randomized run after the reset to confirm normal operation resumes
      for (int k = 0; k < 50; k++) begin
         applyStimulus(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), $urandom,
                       5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
         checkOutput("post_reset");
         clockEdge("post_reset");
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
